// File: rtl/calc_controller.sv
// Two-operand 4-bit calculator: debounced-edge buttons, ENTRY/CALC/RESULT FSM
// and a four-digit multiplexed active-low 7-segment display.
module calc_controller #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       B1,
  input  logic       B2,
  input  logic       Equals,
  input  logic       op,
  output logic [3:0] Output1,
  output logic [3:0] Output2,
  output logic [3:0] result,
  output logic       ovf,
  output logic       done,
  output logic [1:0] state,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {
    ENTRY  = 2'b00,
    CALC   = 2'b01,
    RESULT = 2'b10
  } state_t;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  // Button lanes: bit 0 = B1, bit 1 = B2, bit 2 = Equals
  logic [2:0] s1, s2, s3;
  logic [2:0] armed;
  logic       sampled;
  logic [2:0] press;
  logic       b1_p, b2_p, eq_p;

  state_t     cur, nxt;
  logic [3:0] o1_n, o2_n, res_n;
  logic       ovf_n, done_n;
  logic [4:0] sum;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          blank;

  // A lane is armed only once a genuine low sample has passed s1 after reset,
  // so a button held across reset release cannot produce a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      armed   <= '0;
      sampled <= 1'b0;
    end else begin
      s1      <= {Equals, B2, B1};
      s2      <= s1;
      s3      <= s2;
      sampled <= 1'b1;
      armed   <= armed | ({3{sampled}} & ~s1);
    end
  end

  assign press = s2 & ~s3 & armed;
  assign b1_p  = press[0];
  assign b2_p  = press[1];
  assign eq_p  = press[2];
  assign sum   = {1'b0, Output1} + {1'b0, Output2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= ENTRY;
      Output1 <= 4'd0;
      Output2 <= 4'd0;
      result  <= 4'd0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      cur     <= nxt;
      Output1 <= o1_n;
      Output2 <= o2_n;
      result  <= res_n;
      ovf     <= ovf_n;
      done    <= done_n;
    end
  end

  // Equals always outranks operand buttons; CALC lasts exactly one cycle.
  always_comb begin
    nxt    = cur;
    o1_n   = Output1;
    o2_n   = Output2;
    res_n  = result;
    ovf_n  = ovf;
    done_n = 1'b0;
    case (cur)
      ENTRY: begin
        if (eq_p) begin
          nxt = CALC;
        end else begin
          if (b1_p) o1_n = Output1 + 4'd1;
          if (b2_p) o2_n = Output2 + 4'd1;
        end
      end
      CALC: begin
        nxt    = RESULT;
        done_n = 1'b1;
        if (op) begin
          res_n = Output1 - Output2;
          ovf_n = (Output1 < Output2);
        end else begin
          res_n = sum[3:0];
          ovf_n = sum[4];
        end
      end
      RESULT: begin
        if (eq_p) begin
          nxt = CALC;
        end else if (b1_p || b2_p) begin
          nxt  = ENTRY;
          o1_n = b1_p ? 4'd1 : 4'd0;
          o2_n = b2_p ? 4'd1 : 4'd0;
        end
      end
      default: nxt = ENTRY;
    endcase
  end

  assign state = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // Digit 3 is an overflow indicator: "1" when set, dark otherwise.
  always_comb begin
    an    = 4'b1110;
    nib   = Output1;
    blank = 1'b0;
    case (idx)
      2'd0: begin an = 4'b1110; nib = Output1; end
      2'd1: begin an = 4'b1101; nib = Output2; end
      2'd2: begin an = 4'b1011; nib = result;  end
      default: begin an = 4'b0111; nib = 4'd1; blank = ~ovf; end
    endcase
    seg = blank ? 7'b1111111 : hex_glyph(nib);
  end

endmodule

// File: tb/tb_calc_controller.sv
// Directed self-checking bench for calc_controller with hand-computed expectations.
module tb_calc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       B1 = 1'b0, B2 = 1'b0, Equals = 1'b0, op = 1'b0;
  logic [3:0] Output1, Output2, result;
  logic       ovf, done;
  logic [1:0] state;
  logic [3:0] an;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  calc_controller #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .B1(B1), .B2(B2), .Equals(Equals), .op(op),
    .Output1(Output1), .Output2(Output2), .result(result), .ovf(ovf),
    .done(done), .state(state), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle button pulse; returns at the negedge after the acting edge.
  task automatic apply_stimulus(input logic b1, input logic b2, input logic eq);
    @(negedge clk);
    B1 = b1; B2 = b2; Equals = eq;
    @(negedge clk);
    B1 = 1'b0; B2 = 1'b0; Equals = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic press_n(input int n, input logic which_b2);
    for (int i = 0; i < n; i++) apply_stimulus(!which_b2, which_b2, 1'b0);
  endtask

  // Equals then follow CALC into RESULT, checking the single done pulse.
  task automatic compute(input string tag, input logic [3:0] exp_res, input logic exp_ovf);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output({tag, "_calc_state"}, state, 8'h1);
    check_output({tag, "_calc_done"}, done, 8'h0);
    @(negedge clk);
    check_output({tag, "_state"}, state, 8'h2);
    check_output({tag, "_result"}, result, exp_res);
    check_output({tag, "_ovf"}, ovf, exp_ovf);
    check_output({tag, "_done"}, done, 8'h1);
    @(negedge clk);
    check_output({tag, "_done_low"}, done, 8'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rst_state", state, 8'h0);
    check_output("rst_o1", Output1, 8'h0);
    check_output("rst_o2", Output2, 8'h0);
    check_output("rst_res", result, 8'h0);
    check_output("rst_ovf", ovf, 8'h0);
    check_output("rst_done", done, 8'h0);
    check_output("rst_an", an, 8'b1110);
    check_output("rst_seg", seg, 8'b1000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_seg[0] = 7'b1000000; exp_seg[1] = 7'b1000000;
    exp_seg[2] = 7'b1000000; exp_seg[3] = 7'b1111111;

    do_reset();

    // Display scan from a known phase: four cycles per digit.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check_output($sformatf("scan_an_%0d", k), an, exp_an[(k / 4) % 4]);
      check_output($sformatf("scan_seg_%0d", k), seg, exp_seg[(k / 4) % 4]);
    end

    // Basic add: 3 + 2
    press_n(3, 1'b0);
    press_n(2, 1'b1);
    check_output("entry_o1", Output1, 8'h3);
    check_output("entry_o2", Output2, 8'h2);
    check_output("entry_state", state, 8'h0);
    op = 1'b0;
    compute("add_3_2", 4'd5, 1'b0);

    // Leaving RESULT with B1 clears operands then applies the increment.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("res_b1_state", state, 8'h0);
    check_output("res_b1_o1", Output1, 8'h1);
    check_output("res_b1_o2", Output2, 8'h0);
    check_output("res_b1_hold", result, 8'h5);

    press_n(8, 1'b0);
    press_n(8, 1'b1);
    check_output("o1_9", Output1, 8'h9);
    check_output("o2_8", Output2, 8'h8);
    compute("add_9_8", 4'd1, 1'b1);
    op = 1'b1;
    compute("sub_9_8", 4'd1, 1'b0);

    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("sub_prep_hold", result, 8'h1);
    press_n(1, 1'b0);
    press_n(5, 1'b1);
    compute("sub_2_5", 4'd13, 1'b1);

    // B2 out of RESULT, then B1 and Equals together in ENTRY.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("res_b2_state", state, 8'h0);
    check_output("res_b2_o1", Output1, 8'h0);
    check_output("res_b2_o2", Output2, 8'h1);
    check_output("res_b2_hold", result, 8'hD);
    compute("sub_0_1", 4'd15, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("b1eq_state", state, 8'h1);
    check_output("b1eq_o1", Output1, 8'h0);
    @(negedge clk);
    check_output("b1eq_res", result, 8'hF);

    // Equals coincident with B1 in RESULT: recompute, operands untouched.
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("res_b1eq_state", state, 8'h1);
    check_output("res_b1eq_o1", Output1, 8'h0);
    check_output("res_b1eq_o2", Output2, 8'h1);
    @(negedge clk);

    // Wraparound and long hold.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    press_n(15, 1'b0);
    check_output("o1_15", Output1, 8'hF);
    press_n(1, 1'b0);
    check_output("o1_wrap", Output1, 8'h0);
    @(negedge clk);
    B1 = 1'b1;
    repeat (50) @(negedge clk);
    B1 = 1'b0;
    repeat (3) @(negedge clk);
    check_output("hold_once", Output1, 8'h1);

    // Reset in the middle of CALC.
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("abort_pre_state", state, 8'h1);
    #1 rst = 1'b1;
    #1;
    check_output("abort_state", state, 8'h0);
    check_output("abort_o1", Output1, 8'h0);
    check_output("abort_o2", Output2, 8'h0);
    check_output("abort_res", result, 8'h0);
    check_output("abort_ovf", ovf, 8'h0);
    check_output("abort_an", an, 8'b1110);
    check_output("abort_seg", seg, 8'b1000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output($sformatf("abort_no_done_%0d", k), done, 8'h0);
    end
    check_output("abort_final_state", state, 8'h0);

    // Button held across reset release must not count.
    @(negedge clk);
    rst = 1'b1;
    B1  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    B1 = 1'b0;
    repeat (4) @(negedge clk);
    check_output("held_rst_o1", Output1, 8'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("after_held_o1", Output1, 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
